// File: rtl/pc_seq_if.sv
// pc_seq_if -- control/bus bundle between the control FSM, the PC sequencer
// and instruction memory.
//
// Signals:
//   i_en        advance strobe from the control FSM
//   i_op        operation select (3 bits), valid when i_en=1
//   i_addr      absolute target for JUMP and CALL
//   i_offset    two's-complement BRANCH offset
//   i_flag_clr  clears the sticky overflow/underflow flags
//   o_addr_pc   current program counter
//   o_ras_empty return-address stack holds no entries
//   o_ras_full  return-address stack holds RAS_DEPTH entries
//   o_ovf       sticky: CALL while the stack was full
//   o_unf       sticky: RET while the stack was empty
//
// Modports: master = control side (drives i_*), slave = pc_seq (drives o_*).
interface pc_seq_if #(
    parameter int AW = 8
);
    logic          i_en;
    logic [2:0]    i_op;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] i_offset;
    logic          i_flag_clr;
    logic [AW-1:0] o_addr_pc;
    logic          o_ras_empty;
    logic          o_ras_full;
    logic          o_ovf;
    logic          o_unf;

    modport master (
        output i_en, i_op, i_addr, i_offset, i_flag_clr,
        input  o_addr_pc, o_ras_empty, o_ras_full, o_ovf, o_unf
    );

    modport slave (
        input  i_en, i_op, i_addr, i_offset, i_flag_clr,
        output o_addr_pc, o_ras_empty, o_ras_full, o_ovf, o_unf
    );
endinterface

// File: rtl/pc_seq.sv
// pc_seq -- program-counter sequencer for the bit-serial core.
//
// Sequences the instruction address register with HOLD, INCR, JUMP, BRANCH,
// CALL and RET. CALL/RET use a circular return-address stack (RAS).
//
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous reset, active-high
//   bus    pc_seq_if.slave (op/enable/targets in, PC and RAS status out)
//
// Optional feature: define PC_SEQ_RAS_EN to build the return-address stack
// and the o_ovf/o_unf flags. Without it, CALL behaves as JUMP, RET as HOLD,
// o_ras_empty=1, o_ras_full=o_ovf=o_unf=0 and i_flag_clr is ignored.
module pc_seq #(
    parameter int AW        = 8,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4,
    parameter int RST_ADDR  = 0
) (
    input  logic     i_clk,
    input  logic     i_rst,
    pc_seq_if.slave  bus
);
    localparam logic [2:0] OP_INCR   = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;

    localparam logic [AW-1:0] STEP_V = AW'(STEP);
    localparam logic [AW-1:0] RST_V  = AW'(RST_ADDR);

    // Modulo-2^AW add of a signed offset; wrap-around is silent by design.
    function automatic logic [AW-1:0] add_offset(input logic [AW-1:0] base,
                                                 input logic signed [AW-1:0] off);
        return base + $unsigned(off);
    endfunction

    logic [AW-1:0]        pc;
    logic [AW-1:0]        pc_step;
    logic [AW-1:0]        pc_branch;
    logic signed [AW-1:0] offset_s;

    assign offset_s      = bus.i_offset;
    assign pc_step       = pc + STEP_V;
    assign pc_branch     = add_offset(pc, offset_s);
    assign bus.o_addr_pc = pc;

`ifdef PC_SEQ_RAS_EN
    localparam int            PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0]   DEPTH_V = (PW+1)'(RAS_DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] WP_ONE  = PW'(1);

    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] wp_dec;
    logic [PW:0]   cnt;
    logic          ras_empty;
    logic          ras_full;
    logic          do_call;
    logic          do_ret;
    logic          ovf;
    logic          unf;

    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == DEPTH_V);
    assign do_call   = bus.i_en && (bus.i_op == OP_CALL);
    assign do_ret    = bus.i_en && (bus.i_op == OP_RET);
    assign wp_dec    = wp - WP_ONE;

    // Stack storage carries no reset; entries are only read once pushed.
    // When full, wp already points at the oldest entry, so the push
    // overwrites it.
    always_ff @(posedge i_clk) begin
        if (do_call)
            ras_mem[wp] <= pc_step;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (do_call) begin
                wp <= wp + WP_ONE;
                if (!ras_full)
                    cnt <= cnt + CNT_ONE;
            end else if (do_ret && !ras_empty) begin
                wp  <= wp_dec;
                cnt <= cnt - CNT_ONE;
            end
            // A new error in the same cycle as a clear leaves the flag set.
            if (do_call && ras_full)
                ovf <= 1'b1;
            else if (bus.i_flag_clr)
                ovf <= 1'b0;
            if (do_ret && ras_empty)
                unf <= 1'b1;
            else if (bus.i_flag_clr)
                unf <= 1'b0;
        end
    end

    assign bus.o_ras_empty = ras_empty;
    assign bus.o_ras_full  = ras_full;
    assign bus.o_ovf       = ovf;
    assign bus.o_unf       = unf;
`else
    logic unused_flag_clr;
    logic [31:0] unused_depth;

    assign unused_flag_clr = bus.i_flag_clr;
    assign unused_depth    = RAS_DEPTH;

    assign bus.o_ras_empty = 1'b1;
    assign bus.o_ras_full  = 1'b0;
    assign bus.o_ovf       = 1'b0;
    assign bus.o_unf       = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc <= RST_V;
        end else if (bus.i_en) begin
            case (bus.i_op)
                OP_INCR:   pc <= pc_step;
                OP_JUMP:   pc <= bus.i_addr;
                OP_BRANCH: pc <= pc_branch;
                OP_CALL:   pc <= bus.i_addr;
`ifdef PC_SEQ_RAS_EN
                // An empty-stack return falls through to the next address.
                OP_RET:    pc <= ras_empty ? pc_step : ras_mem[wp_dec];
`endif
                default:   pc <= pc;
            endcase
        end
    end
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised program-counter sequencer; successor to the 3-bit load-only PC.
- Holds the instruction address register for the bit-serial core and sequences it in six ways: hold, increment, absolute jump, relative branch, call and return.
- Call/return uses a small circular return-address stack (RAS).
- Sits between the control FSM, which drives the op and enable, and instruction memory, which consumes o_addr_pc.

Parameters:
- AW, 8, address width in bits (>=2).
- STEP, 1, increment added by INCR and used to form the CALL return address.
- RAS_DEPTH, 4, number of RAS entries (power of two, >=2).
- RST_ADDR, 0, PC value loaded on reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_en  in  1  advance strobe; when 0, all state holds.
- i_op  in  3  operation select, sampled only when i_en=1.
- i_addr  in  AW  absolute target for JUMP and CALL.
- i_offset  in  AW  two's-complement offset for BRANCH.
- i_flag_clr  in  1  clears the sticky error flags.
- o_addr_pc  out  AW  current PC, driven directly from the register.
- o_ras_empty  out  1  RAS count == 0.
- o_ras_full  out  1  RAS count == RAS_DEPTH.
- o_ovf  out  1  sticky: CALL issued while the RAS was full.
- o_unf  out  1  sticky: RET issued while the RAS was empty.

Behaviour:
- Reset (async, active-high):
  - pc=RST_ADDR, RAS count=0, RAS pointer=0, o_ovf=0, o_unf=0.
  - Therefore o_ras_empty=1 and o_ras_full=0.
  - RAS entry contents are don't-care.
  - Reset asserted mid-operation takes effect immediately; no pending op survives it.
- Priority per rising edge: i_rst > i_en=0 (hold everything except flag clear) > i_op.
- All state changes are registered. The new PC is visible on o_addr_pc one cycle after the edge that samples i_op; no combinational path runs from i_op to o_addr_pc.
- Arithmetic is modulo 2^AW; wrap-around is silent. Examples: pc=0xFF, INCR -> 0x00; pc=0x02, offset 0xFC -> 0xFE.
- i_op encoding:
  - 000 HOLD: pc unchanged.
  - 001 INCR: pc <= pc+STEP.
  - 010 JUMP: pc <= i_addr.
  - 011 BRANCH: pc <= pc+i_offset, where i_offset is sign-extended to AW (already AW wide).
  - 100 CALL: push pc+STEP, then pc <= i_addr.
  - 101 RET: pop the top entry into pc.
  - 110 and 111: reserved; behave as HOLD and set no flag.
- RAS organisation: circular buffer, write pointer wp, count cnt.
  - Push: entry[wp] <= pc+STEP; wp++; cnt <= min(cnt+1, RAS_DEPTH).
  - Pop: wp--; pc <= entry[wp-1]; cnt--.
- Boundary conditions:
  - CALL with RAS full: PC still jumps. The push overwrites the oldest entry (circular), cnt stays at RAS_DEPTH, o_ovf <= 1.
  - RET with RAS empty: pc <= pc+STEP, wp and cnt unchanged, o_unf <= 1.
  - o_ovf and o_unf are sticky until reset or i_flag_clr. i_flag_clr works regardless of i_en.
  - If i_flag_clr coincides with a new error in the same cycle, the set wins (flag reads 1).
  - i_en=0: i_op, i_addr and i_offset are ignored; pc, RAS and flags hold (flags may still be cleared).

Optional Feature:
- Macro: PC_SEQ_RAS_EN.
- Defined: RAS, o_ovf and o_unf behave exactly as described above.
- Undefined:
  - No RAS storage is built.
  - CALL acts as JUMP (no push).
  - RET acts as HOLD.
  - o_ras_empty is tied to 1; o_ras_full, o_ovf and o_unf are tied to 0.
  - i_flag_clr is ignored.
  - All other ops are unchanged.

Test Plan (AW=8, STEP=1, RAS_DEPTH=4, RST_ADDR=0, PC_SEQ_RAS_EN defined unless stated):
- Reset then INCR x3 -> o_addr_pc reads 0x00, 0x01, 0x02, 0x03 on successive cycles. Assert i_rst asynchronously mid-cycle -> o_addr_pc=0x00 immediately, without waiting for a clock edge.
- Wrap and branch:
  - JUMP 0xFF, INCR -> 0x00.
  - JUMP 0x10, BRANCH 0xF0 -> 0x00.
  - BRANCH 0x05 -> 0x05.
  - i_en=0 with i_op=JUMP 0x80 -> stays 0x05.
- Call/return at pc=0x20:
  - CALL 0x40 -> pc=0x40, o_ras_empty=0.
  - CALL 0x60 -> pc=0x60.
  - RET -> pc=0x41.
  - RET -> pc=0x21, o_ras_empty=1, no flags set.
- RAS overflow: from pc=0x00, CALL 0x10, 0x20, 0x30, 0x40 -> o_ras_full=1. A fifth CALL 0x50 -> pc=0x50 and o_ovf=1. Then RET x4 -> pc=0x41, 0x31, 0x21, 0x11 (entry 0x01 was lost).
- RAS underflow and flags:
  - RET with RAS empty at pc=0x07 -> pc=0x08, o_unf=1.
  - i_flag_clr together with another empty RET -> o_unf stays 1.
  - i_flag_clr alone -> o_unf=0.
  - Reserved op 110 -> pc unchanged, no flags set.
- PC_SEQ_RAS_EN undefined: at pc=0x20, CALL 0x40 -> pc=0x40; RET -> pc stays 0x40; o_ras_empty=1, o_ovf=0, o_unf=0 throughout.
